// File: rtl/eth_rx_frame_ctrl_pkg.sv
// Shared types and constants for the per-port Ethernet ingress frame controller.
package eth_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    PARSE_ADDR    = 3'd1,
    GET_LENGTH    = 3'd2,
    PAYLOAD       = 3'd3,
    FCS_CHECK     = 3'd4,
    MAC_LEARN     = 3'd5,
    OUT_SEND      = 3'd6,
    DELETE_PACKET = 3'd7
  } RX_STATE_t;

  localparam int          MAC_W         = 48;
  localparam int          NUM_OF_PORTS  = 8;
  localparam int          PORT_W        = $clog2(NUM_OF_PORTS);
  localparam int          ETH_MIN_LEN   = 64;
  localparam int          ETH_MAX_LEN   = 1518;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // 16-bit add that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    if (s[16]) begin
      return 16'hFFFF;
    end else begin
      return s[15:0];
    end
  endfunction

endpackage

// File: rtl/eth_rx_frame_ctrl_crc32.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32 (LSB first).
module eth_crc32_d8
  import eth_rx_frame_ctrl_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight serial LFSR steps unrolled into one combinational byte update.
  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0]) begin
        crc_out = {1'b0, crc_out[31:1]} ^ CRC32_POLY;
      end else begin
        crc_out = {1'b0, crc_out[31:1]};
      end
    end
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Per-port ingress frame controller: buffers MAC bytes, parses the header,
// validates FCS/length/overflow, then learns+commits good frames or rewinds bad ones.
module eth_rx_frame_ctrl
  import eth_rx_frame_ctrl_pkg::*;
#(
  parameter logic [PORT_W-1:0] PORT_ID       = {PORT_W{1'b0}},
  parameter int                BUF_ADDR_W    = 11,
  parameter int                MIN_FRAME_LEN = ETH_MIN_LEN,
  parameter int                MAX_FRAME_LEN = ETH_MAX_LEN,
  parameter bit                FCS_STRIP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_last,
  input  logic                  rx_err,
  input  logic [BUF_ADDR_W:0]   buf_free,
  output logic                  buf_wr_en,
  output logic [BUF_ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]            buf_wr_data,
  output logic                  learn_valid,
  output logic [MAC_W-1:0]      learn_mac,
  output logic [PORT_W-1:0]     learn_port,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [BUF_ADDR_W-1:0] commit_start,
  output logic [15:0]           commit_len,
  output logic [MAC_W-1:0]      commit_dst,
  output logic [15:0]           commit_type,
  output logic                  drop_pulse,
  output logic [15:0]           drop_cnt,
  output RX_STATE_t             state
);

  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_LEN);
  localparam logic [15:0] FCS_BYTES = 16'd4;

  RX_STATE_t             state_r, state_nxt_s;
  logic [BUF_ADDR_W-1:0] wr_ptr_r, frame_start_r;
  logic [15:0]           len_r, commit_len_s;
  logic [31:0]           crc_r, crc_nxt_s;
  logic [MAC_W-1:0]      dst_r, src_r;
  logic [15:0]           type_r;
  logic                  err_r, ovf_r, short_r, skip_r;
  logic                  in_frame_s, post_s, accept_s, ovf_hit_s, wr_en_s;
  logic                  skip_byte_s, skip_drop_s;
  logic                  frame_bad_s, frame_drop_s, frame_pass_s;

  logic                  buf_wr_en_r, learn_valid_r, commit_valid_r, drop_pulse_r;
  logic [BUF_ADDR_W-1:0] buf_wr_addr_r, commit_start_r;
  logic [7:0]            buf_wr_data_r;
  logic [MAC_W-1:0]      learn_mac_r, commit_dst_r;
  logic [PORT_W-1:0]     learn_port_r;
  logic [15:0]           commit_len_r, commit_type_r, drop_cnt_r;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_r),
    .data    (rx_data),
    .crc_out (crc_nxt_s)
  );

  // IDLE only starts a frame when not still discarding a gap-violating burst.
  assign in_frame_s  = (state_r inside {PARSE_ADDR, GET_LENGTH, PAYLOAD}) ||
                       ((state_r == IDLE) && !skip_r);
  assign post_s      = state_r inside {FCS_CHECK, MAC_LEARN, OUT_SEND, DELETE_PACKET};
  assign accept_s    = rx_valid && in_frame_s;
  assign ovf_hit_s   = accept_s && (ovf_r || (32'(len_r) >= 32'(buf_free)));
  assign wr_en_s     = accept_s && !ovf_hit_s;
  assign skip_byte_s = rx_valid && (post_s || ((state_r == IDLE) && skip_r));
  assign skip_drop_s = skip_byte_s && rx_last;

  assign frame_bad_s  = (crc_r != CRC32_RESIDUE) || err_r || ovf_r || short_r ||
                        (len_r < MIN_LEN) || (len_r > MAX_LEN);
  assign frame_drop_s = (state_r == FCS_CHECK) && frame_bad_s;
  assign frame_pass_s = (state_r == FCS_CHECK) && !frame_bad_s;
  assign commit_len_s = FCS_STRIP ? (len_r - FCS_BYTES) : len_r;

  // Receive/verdict state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; byte index within the frame is the running length.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = rx_last ? FCS_CHECK : PARSE_ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PARSE_ADDR: begin
        if (accept_s && rx_last) begin
          state_nxt_s = FCS_CHECK;
        end else if (accept_s && (len_r == 16'd11)) begin
          state_nxt_s = GET_LENGTH;
        end else begin
          state_nxt_s = PARSE_ADDR;
        end
      end
      GET_LENGTH: begin
        if (accept_s && rx_last) begin
          state_nxt_s = FCS_CHECK;
        end else if (accept_s && (len_r == 16'd13)) begin
          state_nxt_s = PAYLOAD;
        end else begin
          state_nxt_s = GET_LENGTH;
        end
      end
      PAYLOAD: begin
        if (accept_s && rx_last) begin
          state_nxt_s = FCS_CHECK;
        end else begin
          state_nxt_s = PAYLOAD;
        end
      end
      FCS_CHECK:     state_nxt_s = frame_bad_s ? DELETE_PACKET : MAC_LEARN;
      MAC_LEARN:     state_nxt_s = OUT_SEND;
      OUT_SEND: begin
        if (commit_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT_SEND;
        end
      end
      DELETE_PACKET: state_nxt_s = IDLE;
      default:       state_nxt_s = IDLE;
    endcase
  end

  // Write pointer: advance per written byte, rewind on drop, trim FCS on pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {BUF_ADDR_W{1'b0}};
    end else if (wr_en_s) begin
      wr_ptr_r <= wr_ptr_r + {{(BUF_ADDR_W-1){1'b0}}, 1'b1};
    end else if (frame_drop_s) begin
      wr_ptr_r <= frame_start_r;
    end else if (frame_pass_s && FCS_STRIP) begin
      wr_ptr_r <= frame_start_r + commit_len_s[BUF_ADDR_W-1:0];
    end
  end

  // Per-frame accumulation; every consumer samples it on the FCS_CHECK edge, so it clears there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_r <= {BUF_ADDR_W{1'b0}};
      len_r         <= 16'd0;
      crc_r         <= CRC32_INIT;
      err_r         <= 1'b0;
      ovf_r         <= 1'b0;
      short_r       <= 1'b0;
      dst_r         <= {MAC_W{1'b0}};
      src_r         <= {MAC_W{1'b0}};
      type_r        <= 16'd0;
    end else if (accept_s) begin
      if (state_r == IDLE) begin
        frame_start_r <= wr_ptr_r;
      end
      len_r   <= sat_add16(len_r, 2'd1);
      crc_r   <= crc_nxt_s;
      err_r   <= err_r | rx_err;
      ovf_r   <= ovf_r | ovf_hit_s;
      short_r <= short_r | (rx_last && (len_r < 16'd13));
      if (len_r < 16'd6) begin
        dst_r <= {dst_r[MAC_W-9:0], rx_data};
      end else if (len_r < 16'd12) begin
        src_r <= {src_r[MAC_W-9:0], rx_data};
      end else if (len_r < 16'd14) begin
        type_r <= {type_r[7:0], rx_data};
      end
    end else if (state_r == FCS_CHECK) begin
      len_r   <= 16'd0;
      crc_r   <= CRC32_INIT;
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
      short_r <= 1'b0;
    end
  end

  // Discard bytes that violate the inter-frame gap up to their rx_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_r <= 1'b0;
    end else if (skip_byte_s) begin
      skip_r <= !rx_last;
    end
  end

  // Buffer write port, one cycle behind the accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wr_en_r   <= 1'b0;
      buf_wr_addr_r <= {BUF_ADDR_W{1'b0}};
      buf_wr_data_r <= 8'd0;
    end else begin
      buf_wr_en_r <= wr_en_s;
      if (wr_en_s) begin
        buf_wr_addr_r <= wr_ptr_r;
        buf_wr_data_r <= rx_data;
      end
    end
  end

  // Learn pulse and commit handshake; commit data is frozen from the pass verdict on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      learn_valid_r  <= 1'b0;
      learn_mac_r    <= {MAC_W{1'b0}};
      learn_port_r   <= {PORT_W{1'b0}};
      commit_valid_r <= 1'b0;
      commit_start_r <= {BUF_ADDR_W{1'b0}};
      commit_len_r   <= 16'd0;
      commit_dst_r   <= {MAC_W{1'b0}};
      commit_type_r  <= 16'd0;
    end else begin
      learn_valid_r <= frame_pass_s && !src_r[40];
      if (frame_pass_s) begin
        learn_mac_r    <= src_r;
        learn_port_r   <= PORT_ID;
        commit_start_r <= frame_start_r;
        commit_len_r   <= commit_len_s;
        commit_dst_r   <= dst_r;
        commit_type_r  <= type_r;
      end
      if (state_r == MAC_LEARN) begin
        commit_valid_r <= 1'b1;
      end else if ((state_r == OUT_SEND) && commit_ready) begin
        commit_valid_r <= 1'b0;
      end
    end
  end

  // Drop accounting; a rejected frame and a gap-violation burst may end together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_r <= 1'b0;
      drop_cnt_r   <= 16'd0;
    end else begin
      drop_pulse_r <= frame_drop_s | skip_drop_s;
      drop_cnt_r   <= sat_add16(drop_cnt_r, 2'({1'b0, frame_drop_s}) + 2'({1'b0, skip_drop_s}));
    end
  end

  assign buf_wr_en    = buf_wr_en_r;
  assign buf_wr_addr  = buf_wr_addr_r;
  assign buf_wr_data  = buf_wr_data_r;
  assign learn_valid  = learn_valid_r;
  assign learn_mac    = learn_mac_r;
  assign learn_port   = learn_port_r;
  assign commit_valid = commit_valid_r;
  assign commit_start = commit_start_r;
  assign commit_len   = commit_len_r;
  assign commit_dst   = commit_dst_r;
  assign commit_type  = commit_type_r;
  assign drop_pulse   = drop_pulse_r;
  assign drop_cnt     = drop_cnt_r;
  assign state        = state_r;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed self-checking bench for eth_rx_frame_ctrl: good/bad FCS, length limits,
// pointer wrap, buffer overflow, commit back-pressure and multicast source.
module tb_eth_rx_frame_ctrl;
  import eth_rx_frame_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, rx_last, rx_err, commit_ready;
  logic [7:0]  rx_data;
  logic [11:0] buf_free;
  logic        buf_wr_en, learn_valid, commit_valid, drop_pulse;
  logic [10:0] buf_wr_addr, commit_start;
  logic [7:0]  buf_wr_data;
  logic [47:0] learn_mac, commit_dst;
  logic [2:0]  learn_port;
  logic [15:0] commit_len, commit_type, drop_cnt;
  RX_STATE_t   state;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_total = 0;
  logic [10:0] wa_log [0:8191];
  logic [7:0]  wd_log [0:8191];
  logic [7:0]  fr [0:2047];

  always #5 clk = ~clk;

  eth_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_last(rx_last), .rx_err(rx_err), .buf_free(buf_free),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .learn_valid(learn_valid), .learn_mac(learn_mac), .learn_port(learn_port),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_start(commit_start), .commit_len(commit_len), .commit_dst(commit_dst),
    .commit_type(commit_type), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt),
    .state(state)
  );

  // Log every buffer write, sampled on the falling edge.
  always @(negedge clk) begin
    if (buf_wr_en) begin
      wa_log[wr_total[12:0]] <= buf_wr_addr;
      wd_log[wr_total[12:0]] <= buf_wr_data;
      wr_total <= wr_total + 1;
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                       input int n, input bit bad_fcs);
    logic [31:0] c;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = dst[47-8*i -: 8];
      fr[6 + i] = src[47-8*i -: 8];
    end
    fr[12] = typ[15:8];
    fr[13] = typ[7:0];
    for (int i = 14; i < n - 4; i++) fr[i] = 8'(i * 13 + 5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr[n - 4 + i] = c[8*i +: 8];
    if (bad_fcs) fr[n - 1] = fr[n - 1] ^ 8'hFF;
  endtask

  // Drives n bytes one per cycle; returns on the falling edge of cycle T+1.
  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = fr[i];
      rx_last  = (i == n - 1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic gap();
    repeat (12) @(negedge clk);
  endtask

  // Good frame up to the first commit_valid cycle (T+3).
  task automatic expect_good(input string tag, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int n, input logic [10:0] start,
                             input bit learn, output int base);
    base = wr_total;
    send_frame(n);
    chk({tag, ".st_fcs"}, 64'(state), 64'(FCS_CHECK));
    @(negedge clk);
    chk({tag, ".learn_v"}, 64'(learn_valid), 64'(learn));
    chk({tag, ".learn_mac"}, 64'(learn_mac), 64'(src));
    chk({tag, ".learn_port"}, 64'(learn_port), 64'd0);
    chk({tag, ".no_drop"}, 64'(drop_pulse), 64'd0);
    @(negedge clk);
    chk({tag, ".cv"}, 64'(commit_valid), 64'd1);
    chk({tag, ".clen"}, 64'(commit_len), 64'(n - 4));
    chk({tag, ".cstart"}, 64'(commit_start), 64'(start));
    chk({tag, ".cdst"}, 64'(commit_dst), 64'(dst));
    chk({tag, ".ctype"}, 64'(commit_type), 64'(typ));
  endtask

  task automatic finish_commit(input string tag, input int base, input int n, input logic [10:0] start);
    @(negedge clk);
    chk({tag, ".cv_done"}, 64'(commit_valid), 64'd0);
    chk({tag, ".st_idle"}, 64'(state), 64'(IDLE));
    @(negedge clk);
    chk({tag, ".nwr"}, 64'(wr_total - base), 64'(n));
    chk({tag, ".wa0"}, 64'(wa_log[base[12:0]]), 64'(start));
    chk({tag, ".wd0"}, 64'(wd_log[base[12:0]]), 64'(fr[0]));
  endtask

  task automatic expect_drop(input string tag, input int n, input int exp_cnt, input int exp_wr);
    int base;
    base = wr_total;
    send_frame(n);
    chk({tag, ".st_fcs"}, 64'(state), 64'(FCS_CHECK));
    @(negedge clk);
    chk({tag, ".drop"}, 64'(drop_pulse), 64'd1);
    chk({tag, ".dcnt"}, 64'(drop_cnt), 64'(exp_cnt));
    chk({tag, ".no_learn"}, 64'(learn_valid), 64'd0);
    chk({tag, ".st_del"}, 64'(state), 64'(DELETE_PACKET));
    @(negedge clk);
    chk({tag, ".no_commit"}, 64'(commit_valid), 64'd0);
    chk({tag, ".drop_off"}, 64'(drop_pulse), 64'd0);
    chk({tag, ".st_idle"}, 64'(state), 64'(IDLE));
    @(negedge clk);
    chk({tag, ".nwr"}, 64'(wr_total - base), 64'(exp_wr));
  endtask

  initial begin
    int base;
    rst_n = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    buf_free = 12'd2048; commit_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.state", 64'(state), 64'(IDLE));
    chk("rst.wr_en", 64'(buf_wr_en), 64'd0);
    chk("rst.learn", 64'(learn_valid), 64'd0);
    chk("rst.commit", 64'(commit_valid), 64'd0);
    chk("rst.drop", 64'(drop_pulse), 64'd0);
    chk("rst.dcnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    gap();

    // Corrupted last FCS byte.
    build(48'h01005E000001, 48'h001122334455, 16'h0800, 64, 1'b1);
    expect_drop("badfcs", 64, 1, 64);
    gap();

    // Good 64-byte frame at address 0; wr_ptr then sits at 60.
    build(48'h01005E000001, 48'h001122334455, 16'h0800, 64, 1'b0);
    expect_good("good64", 48'h01005E000001, 48'h001122334455, 16'h0800, 64, 11'd0, 1'b1, base);
    finish_commit("good64", base, 64, 11'd0);
    gap();

    // Runt with valid CRC, then one byte over the maximum.
    build(48'h0A0B0C0D0E0F, 48'h001122334455, 16'h0800, 60, 1'b0);
    expect_drop("runt60", 60, 2, 60);
    gap();
    build(48'h0A0B0C0D0E0F, 48'h001122334455, 16'h0800, 1519, 1'b0);
    expect_drop("long1519", 1519, 3, 1519);
    gap();

    // Maximum length from 60; wr_ptr then 60 + 1514 = 1574.
    build(48'h0A0B0C0D0E0F, 48'h00AABBCCDDEE, 16'h86DD, 1518, 1'b0);
    expect_good("max1518", 48'h0A0B0C0D0E0F, 48'h00AABBCCDDEE, 16'h86DD, 1518, 11'd60, 1'b1, base);
    finish_commit("max1518", base, 1518, 11'd60);
    gap();

    // 470-byte frame commits 466 bytes, leaving wr_ptr at 2040.
    build(48'h0A0B0C0D0E0F, 48'h00AABBCCDDEE, 16'h0806, 470, 1'b0);
    expect_good("f470", 48'h0A0B0C0D0E0F, 48'h00AABBCCDDEE, 16'h0806, 470, 11'd1574, 1'b1, base);
    finish_commit("f470", base, 470, 11'd1574);
    gap();

    // Frame starting at 2040 wraps: its 9th byte lands at address 0; wr_ptr ends at 52.
    build(48'h01005E000001, 48'h001122334455, 16'h0800, 64, 1'b0);
    expect_good("wrap", 48'h01005E000001, 48'h001122334455, 16'h0800, 64, 11'd2040, 1'b1, base);
    finish_commit("wrap", base, 64, 11'd2040);
    chk("wrap.wa8", 64'(wa_log[base[12:0] + 13'd8]), 64'd0);
    chk("wrap.wd8", 64'(wd_log[base[12:0] + 13'd8]), 64'(fr[8]));
    chk("wrap.wa7", 64'(wa_log[base[12:0] + 13'd7]), 64'd2047);
    gap();

    // Only 40 bytes of space: 40 writes then drop.
    buf_free = 12'd40;
    build(48'h01005E000001, 48'h001122334455, 16'h0800, 64, 1'b0);
    expect_drop("ovf", 64, 4, 40);
    buf_free = 12'd2048;
    gap();

    // Multicast source and 10 cycles of back-pressure; starts at 52 after the rewind.
    commit_ready = 1'b0;
    build(48'h00AABBCCDDEE, 48'h030000000001, 16'h0800, 64, 1'b0);
    expect_good("bp", 48'h00AABBCCDDEE, 48'h030000000001, 16'h0800, 64, 11'd52, 1'b0, base);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp.hold_cv", 64'(commit_valid), 64'd1);
      chk("bp.hold_len", 64'(commit_len), 64'd60);
      chk("bp.hold_start", 64'(commit_start), 64'd52);
      chk("bp.hold_dst", 64'(commit_dst), 64'h00AABBCCDDEE);
      chk("bp.hold_st", 64'(state), 64'(OUT_SEND));
    end
    commit_ready = 1'b1;
    finish_commit("bp", base, 64, 11'd52);
    chk("bp.dcnt", 64'(drop_cnt), 64'd4);
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_ctrl.md
# eth_rx_frame_ctrl

Per-port ingress frame controller for the Gb Ethernet switch, replacing the single fixed global-state controller with one instance per port. It accepts the byte stream from a port MAC, writes it into that port's packet buffer, extracts DST/SRC MAC and type/length, and checks FCS, length and overflow. Good frames produce a MAC-learn pulse and a commit handshake toward the forwarding logic. Bad frames are rewound out of the buffer and counted.

## Interface
- PORT_ID, 0: port number reported with learn/commit, width $clog2(NUM_OF_PORTS).
- BUF_ADDR_W, 11: buffer address width (2048 bytes).
- MIN_FRAME_LEN, 64: minimum length incl. FCS.
- MAX_FRAME_LEN, 1518: maximum length incl. FCS.
- FCS_STRIP, 1: 1 = committed length excludes the 4 FCS bytes.

Ports:
- clk  in  1  switch clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte valid (preamble/SFD already stripped).
- rx_data  in  8  frame byte.
- rx_last  in  1  last byte (final FCS byte), qualified by rx_valid.
- rx_err  in  1  MAC error on this byte, qualified by rx_valid.
- buf_free  in  BUF_ADDR_W+1  free bytes in buffer, sampled per byte.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  BUF_ADDR_W  write address.
- buf_wr_data  out  8  write data.
- learn_valid  out  1  one-cycle learn pulse, no handshake.
- learn_mac  out  48  source MAC.
- learn_port  out  $clog2(NUM_OF_PORTS)  = PORT_ID.
- commit_valid  out  1  frame ready for forwarding.
- commit_ready  in  1  forwarding logic accepts.
- commit_start  out  BUF_ADDR_W  first-byte address.
- commit_len  out  16  committed length.
- commit_dst  out  48  destination MAC.
- commit_type  out  16  type/length field.
- drop_pulse  out  1  one cycle per dropped frame.
- drop_cnt  out  16  dropped frames, saturates at 0xFFFF.
- state  out  RX_STATE_t  debug.

## Operation
- States: IDLE, PARSE_ADDR, GET_LENGTH, PAYLOAD, FCS_CHECK, MAC_LEARN, OUT_SEND, DELETE_PACKET.
- Every accepted byte is written at wr_ptr, and wr_ptr increments mod 2^BUF_ADDR_W (wrap is legal). frame_start is latched to wr_ptr on the first byte.
- Receive-state transitions:
  - IDLE → PARSE_ADDR on the first byte.
  - PARSE_ADDR covers bytes 0–11: bytes 0–5 form dst (byte 0 → [47:40]), bytes 6–11 form src. It → GET_LENGTH after byte 11.
  - GET_LENGTH covers bytes 12–13 (byte 12 → MSB). It → PAYLOAD.
- rx_last in any receive state → FCS_CHECK, including an early rx_last.
- CRC-32 (reflected 0xEDB88320, init 0xFFFFFFFF, no final XOR) runs over all bytes including FCS. Pass condition: register == 0xDEBB20E3.
- len: 16-bit byte count, saturating.
- Error, evaluated in FCS_CHECK, if any of:
  - CRC mismatch;
  - any rx_err in the frame;
  - len < MIN_FRAME_LEN or len > MAX_FRAME_LEN;
  - rx_last before byte 13;
  - overflow: a byte arrives when the count already equals buf_free. That byte and all later bytes are not written.
- Error → DELETE_PACKET: wr_ptr := frame_start, drop_pulse = 1, drop_cnt++ → IDLE.
- Pass → MAC_LEARN: learn_valid = 1 unless src is multicast (src[40] = 1) → OUT_SEND.
- OUT_SEND: commit_valid is held with stable data until commit_ready; the transfer completes in that cycle → IDLE.
  - commit_len = len − 4 if FCS_STRIP, else len.
  - If FCS_STRIP: wr_ptr := frame_start + commit_len, which discards the FCS bytes.
- rx_valid during FCS_CHECK, MAC_LEARN, OUT_SEND or DELETE_PACKET (inter-frame gap violation):
  - the byte is not written;
  - a skip flag is set, and bytes up to and including the next rx_last are discarded;
  - drop_pulse fires and drop_cnt++ once at that rx_last. The in-progress frame still completes normally.

## Timing
- Reset: all outputs 0, state IDLE, wr_ptr 0, drop_cnt 0, CRC 0xFFFFFFFF.
- Reset mid-frame aborts immediately with no commit. The buffer owner is reset by the same rst_n.
- Write latency is 1 cycle: a byte at cycle t appears on buf_wr_* at t+1.
- rx_last at cycle T:
  - FCS_CHECK at T+1;
  - learn_valid or drop_pulse at T+2;
  - commit_valid at the earliest T+3.
- The earliest next frame start is IDLE at T+4. The MAC guarantees a ≥12-cycle inter-frame gap.
- Simultaneous rx_last and overflow: the frame is flagged in error and dropped.

## Structure
- Add to eth_switch_pkg:
  - RX_STATE_t (3-bit enum with the states above);
  - MAC_W = 48;
  - CRC32_RESIDUE = 32'hDEBB20E3;
  - ETH_MIN_LEN and ETH_MAX_LEN.
- Sub-module eth_crc32_d8: combinational byte-wide next-CRC function, instanced once.

## Test plan
- 64-byte frame with dst 01:00:5E:00:00:01, src 00:11:22:33:44:55, valid FCS. Expect:
  - learn_valid at T+2 with learn_mac 0x001122334455;
  - commit_len 60, commit_start 0;
  - commit_type as sent.
- Same frame with the last FCS byte flipped → drop_pulse, drop_cnt 1, no learn/commit. The next frame commits at start 0.
- 60-byte frame with valid CRC (runt) → drop. A 1519-byte frame → drop. A 1518-byte frame → commit_len 1514.
- wr_ptr preloaded at 2040 via prior frames, then a 64-byte good frame → writes wrap to address 0, commit_start 2040.
- buf_free = 40 with a 64-byte frame → only 40 writes, then drop.
- commit_ready held low 10 cycles → commit_valid and data stable. Src 03:00:00:00:00:01 → no learn_valid, commit still issued.
